// File: rtl/lcd_timing_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lcd_timing_gen
// Description : RGB-LCD HS/VS/DE timing generator with one-cycle-early pixel
//               request, start-up mute and end-of-frame pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter logic [10:0] H_SYNC       = 11'd128,
    parameter logic [10:0] H_BACK       = 11'd88,
    parameter logic [10:0] H_DISP       = 11'd800,
    parameter logic [10:0] H_FRONT      = 11'd40,
    parameter logic [10:0] V_SYNC       = 11'd2,
    parameter logic [10:0] V_BACK       = 11'd33,
    parameter logic [10:0] V_DISP       = 11'd480,
    parameter logic [10:0] V_FRONT      = 11'd10,
    parameter logic [3:0]  START_FRAMES = 4'd1
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [23:0] i_pixel_data,
    output logic [10:0] o_pixel_xpos,
    output logic [10:0] o_pixel_ypos,
    output logic [10:0] o_h_disp,
    output logic [10:0] o_v_disp,
    output logic        o_lcd_hs,
    output logic        o_lcd_vs,
    output logic        o_lcd_de,
    output logic [23:0] o_lcd_rgb,
    output logic        o_lcd_bl,
    output logic        o_frame_done
);

    localparam logic [10:0] c_H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] c_V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] c_H_DE_START  = H_SYNC + H_BACK;
    localparam logic [10:0] c_H_DE_END    = c_H_DE_START + H_DISP;
    // The request window opens one cycle ahead of DE to absorb the content
    // stage's register; columns are numbered from 1 so 0 means "no request".
    localparam logic [10:0] c_H_REQ_START = c_H_DE_START - 11'd1;
    localparam logic [10:0] c_H_REQ_END   = c_H_DE_END - 11'd1;
    localparam logic [10:0] c_X_OFFSET    = c_H_DE_START - 11'd2;
    localparam logic [10:0] c_V_ACT_START = V_SYNC + V_BACK;
    localparam logic [10:0] c_V_ACT_END   = c_V_ACT_START + V_DISP;

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [3:0]  r_frame_cnt;
    logic        r_bl;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_done;
    logic        w_v_act;
    logic        w_data_req;
    logic        w_de;
    logic        w_mute;
    logic [3:0]  w_frame_cnt_nxt;

    assign w_h_last     = (r_h_cnt == c_H_TOTAL - 11'd1);
    assign w_v_last     = (r_v_cnt == c_V_TOTAL - 11'd1);
    assign w_frame_done = w_h_last && w_v_last;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 11'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 11'd0;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_cnt <= 11'd0;
        end else if (w_h_last) begin
            if (w_v_last) begin
                r_v_cnt <= 11'd0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end
    end

    assign w_v_act    = (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
    assign w_data_req = w_v_act && (r_h_cnt >= c_H_REQ_START) && (r_h_cnt < c_H_REQ_END);
    assign w_de       = w_v_act && (r_h_cnt >= c_H_DE_START) && (r_h_cnt < c_H_DE_END);

    // Backlight is registered from the next-state mute so it tracks the
    // frame counter exactly, rising in the cycle right after frame_done.
    assign w_mute          = (r_frame_cnt < START_FRAMES);
    assign w_frame_cnt_nxt = (w_frame_done && w_mute) ? r_frame_cnt + 4'd1 : r_frame_cnt;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 4'd0;
            r_bl        <= (START_FRAMES == 4'd0);
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
            r_bl        <= (w_frame_cnt_nxt >= START_FRAMES);
        end
    end

    assign o_lcd_hs     = (r_h_cnt >= H_SYNC);
    assign o_lcd_vs     = (r_v_cnt >= V_SYNC);
    assign o_lcd_de     = w_de;
    assign o_pixel_xpos = w_data_req ? (r_h_cnt - c_X_OFFSET) : 11'd0;
    assign o_pixel_ypos = w_v_act ? (r_v_cnt - c_V_ACT_START) : 11'd0;
    assign o_h_disp     = H_DISP;
    assign o_v_disp     = V_DISP;
    assign o_lcd_rgb    = (w_de && !w_mute) ? i_pixel_data : 24'h000000;
    assign o_lcd_bl     = r_bl;
    assign o_frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_lcd_timing_gen
// Description : Two parameterisations checked cycle by cycle against a
//               frame-position reference model, with random mid-frame resets.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lcd_timing_gen;

    localparam int A_HS = 1, A_HB = 1, A_HD = 4,  A_HF = 1;
    localparam int A_VS = 1, A_VB = 1, A_VD = 3,  A_VF = 1, A_SF = 1;
    localparam int B_HS = 3, B_HB = 4, B_HD = 10, B_HF = 2;
    localparam int B_VS = 2, B_VB = 2, B_VD = 5,  B_VF = 3, B_SF = 0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        bl;
        logic        fd;
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] col;
    } exp_t;

    logic        lcd_pclk = 1'b0;
    logic        rst_n;
    logic [23:0] pix_a, pix_b;
    logic [10:0] a_x, a_y, a_hd, a_vd, b_x, b_y, b_hd, b_vd;
    logic        a_hs, a_vs, a_de, a_bl, a_fd, b_hs, b_vs, b_de, b_bl, b_fd;
    logic [23:0] a_rgb, b_rgb;

    int n_chk = 0;
    int n_fail = 0;
    int t = 0;

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_timing_gen #(
        .H_SYNC(11'(A_HS)), .H_BACK(11'(A_HB)), .H_DISP(11'(A_HD)), .H_FRONT(11'(A_HF)),
        .V_SYNC(11'(A_VS)), .V_BACK(11'(A_VB)), .V_DISP(11'(A_VD)), .V_FRONT(11'(A_VF)),
        .START_FRAMES(4'(A_SF))
    ) u_dut_a (
        .lcd_pclk(lcd_pclk), .rst_n(rst_n), .i_pixel_data(pix_a),
        .o_pixel_xpos(a_x), .o_pixel_ypos(a_y), .o_h_disp(a_hd), .o_v_disp(a_vd),
        .o_lcd_hs(a_hs), .o_lcd_vs(a_vs), .o_lcd_de(a_de), .o_lcd_rgb(a_rgb),
        .o_lcd_bl(a_bl), .o_frame_done(a_fd)
    );

    lcd_timing_gen #(
        .H_SYNC(11'(B_HS)), .H_BACK(11'(B_HB)), .H_DISP(11'(B_HD)), .H_FRONT(11'(B_HF)),
        .V_SYNC(11'(B_VS)), .V_BACK(11'(B_VB)), .V_DISP(11'(B_VD)), .V_FRONT(11'(B_VF)),
        .START_FRAMES(4'(B_SF))
    ) u_dut_b (
        .lcd_pclk(lcd_pclk), .rst_n(rst_n), .i_pixel_data(pix_b),
        .o_pixel_xpos(b_x), .o_pixel_ypos(b_y), .o_h_disp(b_hd), .o_v_disp(b_vd),
        .o_lcd_hs(b_hs), .o_lcd_vs(b_vs), .o_lcd_de(b_de), .o_lcd_rgb(b_rgb),
        .o_lcd_bl(b_bl), .o_frame_done(b_fd)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, act, exp);
        end
    endtask

    // Position within the frame sequence from elapsed cycles since reset.
    function automatic exp_t model(input int hs, input int hb, input int hd, input int hf,
                                   input int vs, input int vb, input int vd, input int vf,
                                   input int sf, input int tc);
        exp_t e;
        int ht, vt, h, v, f;
        bit vact;
        ht = hs + hb + hd + hf;
        vt = vs + vb + vd + vf;
        h = tc % ht;
        v = (tc / ht) % vt;
        f = tc / (ht * vt);
        vact = (v >= vs + vb) && (v < vs + vb + vd);
        e.hs  = (h >= hs);
        e.vs  = (v >= vs);
        e.de  = vact && (h >= hs + hb) && (h < hs + hb + hd);
        e.bl  = (f >= sf);
        e.fd  = (h == ht - 1) && (v == vt - 1);
        e.x   = (vact && (h >= hs + hb - 1) && (h < hs + hb + hd - 1)) ? 11'(h - (hs + hb) + 2) : 11'd0;
        e.y   = vact ? 11'(v - (vs + vb)) : 11'd0;
        e.col = 11'(h - (hs + hb) + 1);
        return e;
    endfunction

    task automatic check_one(input string tag, input exp_t e, input int hd, input int vd,
                             input logic hs, input logic vs, input logic de, input logic bl,
                             input logic fd, input logic [10:0] x, input logic [10:0] y,
                             input logic [10:0] ohd, input logic [10:0] ovd,
                             input logic [23:0] rgb, input logic [23:0] pix);
        logic [23:0] erg;
        erg = (e.de && e.bl) ? {pix[23:11], e.col} : 24'h0;
        chk({tag, ".hs"},   32'(hs),  32'(e.hs));
        chk({tag, ".vs"},   32'(vs),  32'(e.vs));
        chk({tag, ".de"},   32'(de),  32'(e.de));
        chk({tag, ".bl"},   32'(bl),  32'(e.bl));
        chk({tag, ".fd"},   32'(fd),  32'(e.fd));
        chk({tag, ".xpos"}, 32'(x),   32'(e.x));
        chk({tag, ".ypos"}, 32'(y),   32'(e.y));
        chk({tag, ".rgb"},  32'(rgb), 32'(erg));
        chk({tag, ".hdisp"}, 32'(ohd), 32'(hd));
        chk({tag, ".vdisp"}, 32'(ovd), 32'(vd));
    endtask

    task automatic check_all();
        check_one("A", model(A_HS, A_HB, A_HD, A_HF, A_VS, A_VB, A_VD, A_VF, A_SF, t),
                  A_HD, A_VD, a_hs, a_vs, a_de, a_bl, a_fd, a_x, a_y, a_hd, a_vd, a_rgb, pix_a);
        check_one("B", model(B_HS, B_HB, B_HD, B_HF, B_VS, B_VB, B_VD, B_VF, B_SF, t),
                  B_HD, B_VD, b_hs, b_vs, b_de, b_bl, b_fd, b_x, b_y, b_hd, b_vd, b_rgb, pix_b);
    endtask

    // Content stage: registers {random tag, xpos} each clock.
    task automatic run(input int n);
        logic [23:0] na, nb;
        for (int i = 0; i < n; i++) begin
            check_all();
            na = {13'($urandom), a_x};
            nb = {13'($urandom), b_x};
            @(posedge lcd_pclk);
            #1;
            pix_a = na;
            pix_b = nb;
            t++;
            @(negedge lcd_pclk);
            #2;
        end
    endtask

    // Reset asserted away from a clock edge must take effect immediately.
    task automatic reset_pulse();
        rst_n = 1'b0;
        t = 0;
        #1;
        check_all();
        repeat (3) begin
            @(posedge lcd_pclk);
            @(negedge lcd_pclk);
            #2;
            check_all();
        end
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pix_a = 24'($urandom);
        pix_b = 24'($urandom);
        @(negedge lcd_pclk);
        #2;
        reset_pulse();
        run(300);
        for (int k = 0; k < 4; k++) begin
            reset_pulse();
            run($urandom_range(20, 300));
        end
        reset_pulse();
        run(240);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
